pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Parametrised program-counter generator for the RISKY core; the successor to the single-cycle PC register/mux.
- Selects the next PC by priority from sequential, branch, jump, trap (ecall) and mret sources.
- Presents the PC to fetch over a valid/ready handshake and stalls on backpressure.
- Detects misaligned redirect targets, records the faulting PC and target in epc/tval, and counts accepted fetches.

Parameters:
XLEN, 32, width of PC and all address ports
RESET_VECTOR, 0, PC value loaded on reset
MISALIGN_TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned-target exception
ALIGN_BITS, 2, low target bits that must be zero (2 = 4-byte, 1 = 2-byte alignment)
CNT_W, 32, width of fetch counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
pc_ready  input  1  fetch stage accepts the current pc
br_taken  input  1  branch taken this cycle
br_target  input  XLEN  branch target
jmp_valid  input  1  JAL/JALR redirect this cycle
jmp_target  input  XLEN  jump target
trap_valid  input  1  ecall/trap request
trap_target  input  XLEN  trap handler address
mret_valid  input  1  return from trap
halt_req  input  1  enter HALT state
pc  output  XLEN  current PC
pc_4  output  XLEN  pc + 4, modulo 2^XLEN
pc_valid  output  1  pc is presented to fetch
epc  output  XLEN  saved exception PC
tval  output  XLEN  offending target of last misaligned redirect
exc_misalign  output  1  one-cycle pulse: misaligned-target exception taken
halted  output  1  state == HALT
fetch_count  output  CNT_W  number of accepted handshakes

Behaviour:
- Reset (reset == 0, asynchronous): state = BOOT, pc = RESET_VECTOR, epc = 0, tval = 0, fetch_count = 0, exc_misalign = 0, pc_valid = 0, halted = 0. pc_4 always tracks pc combinationally.
- States:
  - BOOT: pc_valid = 0 for exactly one cycle after reset release, then RUN. Redirects are ignored in BOOT.
  - RUN: pc_valid = 1.
  - HALT: pc_valid = 0, halted = 1, pc held.
- "accept" = pc_valid & pc_ready.
- "redirect" = any of trap_valid, mret_valid, jmp_valid, br_taken.
- Next-PC priority in RUN, evaluated each cycle, highest first:
  1. trap_valid: pc <= trap_target, epc <= pc.
  2. mret_valid: pc <= epc.
  3. jmp_valid: pc <= jmp_target.
  4. br_taken: pc <= br_target.
  5. accept: pc <= pc_4.
  6. otherwise: hold pc.
- Redirects take effect regardless of pc_ready; a redirect overrides a stall.
- Misalignment applies to jump and branch targets only:
  - If the selected jmp/br target has any nonzero bit in [ALIGN_BITS-1:0], the redirect is not taken.
  - Instead: pc <= MISALIGN_TRAP_VEC, epc <= pc, tval <= target, exc_misalign = 1 for that one cycle.
  - trap_target and the mret target (epc) are not checked.
- fetch_count increments by 1 on every accept, including accept cycles with a redirect; it wraps at 2^CNT_W.
- HALT entry: halt_req in RUN with no redirect -> HALT at the next edge. A redirect in the same cycle wins and halt_req is ignored that cycle.
- HALT exit: trap_valid -> RUN with pc <= trap_target and epc <= pc. mret_valid -> RUN with pc <= epc. Jump, branch and pc_ready are ignored in HALT.
- pc wraps modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
- All outputs are registered except pc_4 and halted, which are decoded from registers.
- Reset asserted mid-operation immediately forces the reset values listed above.

Test Plan:
- Reset release with RESET_VECTOR = 0x1000, pc_ready = 1 -> pc_valid 0 for one cycle, then pc = 0x1000, 0x1004, 0x1008; fetch_count = 3 after three accepts.
- pc_ready low for 3 cycles at pc = 0x1008 -> pc holds 0x1008 and fetch_count is unchanged; pc_ready high -> pc = 0x100C.
- Same cycle: trap_valid (0x200), jmp_valid (0x3000), br_taken (0x4000), pc = 0x1010 -> pc = 0x200, epc = 0x1010. Next, mret_valid -> pc = 0x1010.
- jmp_valid with jmp_target = 0x2002, ALIGN_BITS = 2, pc = 0x1020 -> pc = 0x100, epc = 0x1020, tval = 0x2002, exc_misalign pulses for exactly 1 cycle. Repeat with ALIGN_BITS = 1 -> pc = 0x2002, no exception.
- halt_req at pc = 0x1040 -> halted = 1, pc_valid = 0, pc holds through 5 cycles with br_taken asserted. trap_valid with target 0x300 -> RUN, pc = 0x300, epc = 0x1040.
- pc = 0xFFFF_FFFC with accept -> pc = 0. Drive reset low asynchronously mid-stall -> pc = RESET_VECTOR, epc = 0, fetch_count = 0 before the next clock edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
//------------------------------------------------------------------------------
// pc_fetch_unit : next-PC selection, fetch handshake, misaligned-target trap
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_fetch_unit #(
   parameter int               XLEN              = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR      = '0,
   parameter logic [XLEN-1:0]  MISALIGN_TRAP_VEC = XLEN'(32'h0000_0100),
   parameter int               ALIGN_BITS        = 2,
   parameter int               CNT_W             = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_ready,
   input  logic              br_taken,
   input  logic [XLEN-1:0]   br_target,
   input  logic              jmp_valid,
   input  logic [XLEN-1:0]   jmp_target,
   input  logic              trap_valid,
   input  logic [XLEN-1:0]   trap_target,
   input  logic              mret_valid,
   input  logic              halt_req,
   output logic [XLEN-1:0]   pc,
   output logic [XLEN-1:0]   pc_4,
   output logic              pc_valid,
   output logic [XLEN-1:0]   epc,
   output logic [XLEN-1:0]   tval,
   output logic              exc_misalign,
   output logic              halted,
   output logic [CNT_W-1:0]  fetch_count
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

   state_t          state, state_nxt;
   logic [XLEN-1:0] pc_nxt, epc_nxt, tval_nxt;
   logic            exc_nxt;
   logic            accept;
   logic            jmp_mis, br_mis;

   assign pc_4    = pc + XLEN'(4);
   assign halted  = (state == HALT);
   assign accept  = pc_valid & pc_ready;
   assign jmp_mis = |(jmp_target & ALIGN_MASK);
   assign br_mis  = |(br_target & ALIGN_MASK);

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      epc_nxt   = epc;
      tval_nxt  = tval;
      exc_nxt   = 1'b0;
      unique case (state)
         BOOT: state_nxt = RUN;
         RUN: begin
            if (trap_valid) begin
               pc_nxt  = trap_target;
               epc_nxt = pc;
            end else if (mret_valid) begin
               pc_nxt = epc;
            end else if (jmp_valid) begin
               if (jmp_mis) begin
                  pc_nxt   = MISALIGN_TRAP_VEC;
                  epc_nxt  = pc;
                  tval_nxt = jmp_target;
                  exc_nxt  = 1'b1;
               end else begin
                  pc_nxt = jmp_target;
               end
            end else if (br_taken) begin
               if (br_mis) begin
                  pc_nxt   = MISALIGN_TRAP_VEC;
                  epc_nxt  = pc;
                  tval_nxt = br_target;
                  exc_nxt  = 1'b1;
               end else begin
                  pc_nxt = br_target;
               end
            end else begin
               // halt only when nothing redirects; an accepted fetch still advances
               if (halt_req) state_nxt = HALT;
               if (accept)   pc_nxt    = pc_4;
            end
         end
         HALT: begin
            if (trap_valid) begin
               state_nxt = RUN;
               pc_nxt    = trap_target;
               epc_nxt   = pc;
            end else if (mret_valid) begin
               state_nxt = RUN;
               pc_nxt    = epc;
            end
         end
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= BOOT;
         pc           <= RESET_VECTOR;
         epc          <= '0;
         tval         <= '0;
         exc_misalign <= 1'b0;
         pc_valid     <= 1'b0;
         fetch_count  <= '0;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         epc          <= epc_nxt;
         tval         <= tval_nxt;
         exc_misalign <= exc_nxt;
         pc_valid     <= (state_nxt == RUN);
         if (accept) fetch_count <= fetch_count + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_pc_fetch_unit : directed scoreboard bench for pc_fetch_unit
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pc_ready = 1'b0, br_taken = 1'b0, jmp_valid = 1'b0;
   logic        trap_valid = 1'b0, mret_valid = 1'b0, halt_req = 1'b0;
   logic [31:0] br_target = '0, jmp_target = '0, trap_target = '0;

   logic [31:0] pc, pc_4, epc, tval, fetch_count;
   logic        pc_valid, exc_misalign, halted;
   logic [31:0] pc_b, pc_4_b, epc_b, tval_b, fetch_count_b;
   logic        pc_valid_b, exc_misalign_b, halted_b;

   always #5 clk = ~clk;

   pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h1000), .MISALIGN_TRAP_VEC(32'h100),
                   .ALIGN_BITS(2), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .pc_ready(pc_ready),
      .br_taken(br_taken), .br_target(br_target),
      .jmp_valid(jmp_valid), .jmp_target(jmp_target),
      .trap_valid(trap_valid), .trap_target(trap_target),
      .mret_valid(mret_valid), .halt_req(halt_req),
      .pc(pc), .pc_4(pc_4), .pc_valid(pc_valid), .epc(epc), .tval(tval),
      .exc_misalign(exc_misalign), .halted(halted), .fetch_count(fetch_count));

   // 2-byte alignment variant driven with identical stimulus
   pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h1000), .MISALIGN_TRAP_VEC(32'h100),
                   .ALIGN_BITS(1), .CNT_W(32)) dut_b (
      .clk(clk), .reset(reset), .pc_ready(pc_ready),
      .br_taken(br_taken), .br_target(br_target),
      .jmp_valid(jmp_valid), .jmp_target(jmp_target),
      .trap_valid(trap_valid), .trap_target(trap_target),
      .mret_valid(mret_valid), .halt_req(halt_req),
      .pc(pc_b), .pc_4(pc_4_b), .pc_valid(pc_valid_b), .epc(epc_b), .tval(tval_b),
      .exc_misalign(exc_misalign_b), .halted(halted_b), .fetch_count(fetch_count_b));

   typedef enum int {S_PC, S_PC4, S_VALID, S_EPC, S_TVAL, S_EXC, S_HALT, S_CNT,
                     S_PC_B, S_EXC_B} sig_t;
   typedef struct { string tag; sig_t sig; logic [31:0] val; } exp_t;

   exp_t sbq[$];
   int   n_pass = 0;
   int   n_total = 0;

   function automatic logic [31:0] observe(input sig_t s);
      case (s)
         S_PC:    return pc;
         S_PC4:   return pc_4;
         S_VALID: return {31'd0, pc_valid};
         S_EPC:   return epc;
         S_TVAL:  return tval;
         S_EXC:   return {31'd0, exc_misalign};
         S_HALT:  return {31'd0, halted};
         S_CNT:   return fetch_count;
         S_PC_B:  return pc_b;
         S_EXC_B: return {31'd0, exc_misalign_b};
         default: return 'x;
      endcase
   endfunction

   task automatic expect_val(input string tag, input sig_t s, input logic [31:0] v);
      exp_t e;
      e.tag = tag; e.sig = s; e.val = v;
      sbq.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      while (sbq.size() > 0) begin
         e   = sbq.pop_front();
         obs = observe(e.sig);
         n_total++;
         assert (obs === e.val) n_pass++;
         else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic clear_redirects();
      br_taken = 1'b0; jmp_valid = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0; halt_req = 1'b0;
   endtask

   initial begin
      #2 reset = 1'b0;
      #1;
      expect_val("rst_pc", S_PC, 32'h1000);
      expect_val("rst_pc4", S_PC4, 32'h1004);
      expect_val("rst_valid", S_VALID, 0);
      expect_val("rst_epc", S_EPC, 0);
      expect_val("rst_tval", S_TVAL, 0);
      expect_val("rst_exc", S_EXC, 0);
      expect_val("rst_halt", S_HALT, 0);
      expect_val("rst_cnt", S_CNT, 0);
      drain();
      reset    = 1'b1;
      pc_ready = 1'b1;
      // BOOT cycle: nothing accepted yet
      expect_val("boot_valid", S_VALID, 1); expect_val("boot_pc", S_PC, 32'h1000);
      expect_val("boot_cnt", S_CNT, 0);
      tick();
      expect_val("seq1_pc", S_PC, 32'h1004); expect_val("seq1_cnt", S_CNT, 1);
      tick();
      expect_val("seq2_pc", S_PC, 32'h1008); expect_val("seq2_cnt", S_CNT, 2);
      tick();
      pc_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expect_val("stall_pc", S_PC, 32'h1008); expect_val("stall_cnt", S_CNT, 2);
         tick();
      end
      pc_ready = 1'b1;
      expect_val("resume_pc", S_PC, 32'h100C); expect_val("resume_cnt", S_CNT, 3);
      tick();
      expect_val("seq3_pc", S_PC, 32'h1010); expect_val("seq3_cnt", S_CNT, 4);
      tick();
      // trap beats jump and branch; the accept still counts
      trap_valid = 1'b1; trap_target = 32'h200;
      jmp_valid = 1'b1;  jmp_target = 32'h3000;
      br_taken = 1'b1;   br_target = 32'h4000;
      expect_val("trap_pc", S_PC, 32'h200); expect_val("trap_epc", S_EPC, 32'h1010);
      expect_val("trap_cnt", S_CNT, 5);
      tick();
      clear_redirects(); pc_ready = 1'b0; mret_valid = 1'b1;
      expect_val("mret_pc", S_PC, 32'h1010); expect_val("mret_cnt", S_CNT, 5);
      tick();
      clear_redirects(); jmp_valid = 1'b1; jmp_target = 32'h1020;
      expect_val("jmp_pc", S_PC, 32'h1020); expect_val("jmp_exc", S_EXC, 0);
      tick();
      jmp_target = 32'h2002; pc_ready = 1'b1;
      expect_val("mis_pc", S_PC, 32'h100); expect_val("mis_epc", S_EPC, 32'h1020);
      expect_val("mis_tval", S_TVAL, 32'h2002); expect_val("mis_exc", S_EXC, 1);
      expect_val("mis_cnt", S_CNT, 6);
      expect_val("a1_pc", S_PC_B, 32'h2002); expect_val("a1_exc", S_EXC_B, 0);
      tick();
      clear_redirects(); pc_ready = 1'b0;
      expect_val("mis_pulse_end", S_EXC, 0); expect_val("mis_hold_pc", S_PC, 32'h100);
      tick();
      br_taken = 1'b1; br_target = 32'h1042;
      expect_val("brmis_pc", S_PC, 32'h100); expect_val("brmis_epc", S_EPC, 32'h100);
      expect_val("brmis_tval", S_TVAL, 32'h1042); expect_val("brmis_exc", S_EXC, 1);
      tick();
      br_target = 32'h1040;
      expect_val("br_pc", S_PC, 32'h1040); expect_val("br_exc", S_EXC, 0);
      tick();
      clear_redirects(); halt_req = 1'b1;
      expect_val("halt_flag", S_HALT, 1); expect_val("halt_valid", S_VALID, 0);
      expect_val("halt_pc", S_PC, 32'h1040);
      tick();
      halt_req = 1'b0; br_taken = 1'b1; br_target = 32'h5000; pc_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         expect_val("halted_pc", S_PC, 32'h1040); expect_val("halted_flag", S_HALT, 1);
         expect_val("halted_cnt", S_CNT, 6);
         tick();
      end
      clear_redirects(); pc_ready = 1'b0; trap_valid = 1'b1; trap_target = 32'h300;
      expect_val("exit_pc", S_PC, 32'h300); expect_val("exit_epc", S_EPC, 32'h1040);
      expect_val("exit_halt", S_HALT, 0); expect_val("exit_valid", S_VALID, 1);
      tick();
      clear_redirects(); jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFC;
      expect_val("top_pc", S_PC, 32'hFFFF_FFFC); expect_val("top_pc4", S_PC4, 32'h0);
      tick();
      clear_redirects(); pc_ready = 1'b1;
      expect_val("wrap_pc", S_PC, 32'h0); expect_val("wrap_cnt", S_CNT, 7);
      tick();
      pc_ready = 1'b0;
      expect_val("stall2_pc", S_PC, 32'h0);
      tick();
      // asynchronous reset between clock edges
      #2 reset = 1'b0;
      #1;
      expect_val("arst_pc", S_PC, 32'h1000); expect_val("arst_epc", S_EPC, 0);
      expect_val("arst_cnt", S_CNT, 0); expect_val("arst_tval", S_TVAL, 0);
      expect_val("arst_valid", S_VALID, 0);
      drain();
      #1 reset = 1'b1;
      expect_val("reboot_valid", S_VALID, 1); expect_val("reboot_pc", S_PC, 32'h1000);
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
